pooled_channel_serializer: RTL and testbench
============================================

# pooled_channel_serializer

Downstream neighbour of the convolution/pooling layer. Collects pooled results arriving as per-kernel valid strobes on shared processing-element data lanes and queues them in a FIFO. Emits them as a single-word valid/ready stream tagged with the kernel (channel) index, ready to feed the next layer's scalar input. Also tracks end-of-image and flags protocol errors.

## Interface
- NumberOfK, 4: kernels (channels) produced upstream; width of `in_valid`.
- ProcessingElements, 2: data lanes; kernel i always uses lane i % ProcessingElements.
- BitSize, 32: word width.
- FifoDepth, 16: entries; power of two, ≥ ProcessingElements.
- ChanBits, $clog2(NumberOfK) (min 1): width of `out_channel`.
- clk  in  1  clock; all state updates on rising edge.
- res_n  in  1  reset, synchronous, active-low.
- in_valid  in  NumberOfK  per-kernel strobe; bit i set means kernel i's result is on lane i % ProcessingElements this cycle.
- in_data  in  ProcessingElements×BitSize  lane data, packed [ProcessingElements-1:0][BitSize-1:0].
- in_done  in  1  upstream pooling-complete level; may stay high.
- out_ready  in  1  downstream accepts a word this cycle.
- out_valid  out  1  FIFO head valid.
- out_data  out  BitSize  FIFO head word.
- out_channel  out  ChanBits  kernel index of the head word.
- out_done  out  1  all results of the image drained.
- overflow  out  1  sticky; a write group was dropped for lack of space.
- lane_conflict  out  1  sticky; two set strobes mapped to the same lane in one cycle.

## Operation
- Write group: the set bits of `in_valid` in one cycle, n = popcount (0..NumberOfK).
- Group is accepted iff n ≤ FifoDepth − count, where count is the registered occupancy at the start of the cycle. A pop in the same cycle is not credited.
- Accepted group: entries are written in ascending kernel index, each as {i, in_data[i % ProcessingElements]}, so the lowest index lands first.
- Rejected group (n > free): none of its entries are written; `overflow` sets. No partial writes.
- Lane conflict: two set bits i≠j with i % PE == j % PE. `lane_conflict` sets. The group is still written under the normal rule, and both entries take the same lane value.
- Pop: when `out_valid && out_ready`, head is removed and the read pointer advances modulo FifoDepth.
- Occupancy: count_next = count + (accepted ? n : 0) − pop. Pointers wrap modulo FifoDepth; count is $clog2(FifoDepth+1) bits.
- Done tracking: a sticky `seen_done` sets on the first cycle `in_done` = 1. `out_done` = seen_done && count == 0 && no write accepted this cycle. It is registered, held high, and cleared only by reset.
- `overflow`, `lane_conflict` and `seen_done` clear only on reset.
- Reset mid-operation: on any edge with res_n = 0, all of the following apply and that cycle's writes and pops are discarded:
  - count and pointers go to 0.
  - Every output goes to 0.
  - Sticky flags clear.

## Timing
- Reset values: out_valid 0, out_data 0, out_channel 0, out_done 0, overflow 0, lane_conflict 0.
- Show-ahead FIFO. `out_valid` = (count ≠ 0); `out_data` and `out_channel` show the head combinationally from storage.
- Latency: a group sampled at edge t gives out_valid = 1 after edge t, provided the FIFO was empty before edge t.
- Throughput: up to NumberOfK writes and 1 read per cycle.
- `out_data` and `out_channel` must hold stable while out_valid && !out_ready.
- Full FIFO with a simultaneous pop and a group of n = 1: the group is rejected (pop not credited) and overflow sets.
- Empty FIFO with simultaneous write: no bypass; data appears the next cycle.
- `overflow` and `lane_conflict` assert the cycle after the offending edge.
- `out_done` rises one cycle after the edge at which count reaches 0 with seen_done set. If in_done arrives with the FIFO already empty, it rises the cycle after in_done is sampled.

## Test plan
- Reset then idle: hold res_n = 0 for 2 cycles, then release with in_valid = 0. Required: all outputs 0 for 10 cycles.
- Ordered group, defaults: in_valid = 4'b0011, in_data = {32'hB, 32'hA}, out_ready = 1. Required: next cycles out (ch0, 0xA) then (ch1, 0xB). Then in_valid = 4'b1100 with lanes {0xD, 0xC}. Required: (ch2, 0xC) then (ch3, 0xD).
- Backpressure: push 6 single-bit groups with out_ready = 0. Required: count = 6 and head stable. Release out_ready. Required: 6 words in push order, one per cycle, then out_valid = 0.
- Overflow, FifoDepth = 4: fill to 3, then in_valid = 4'b0011. Required: group rejected, count stays 3, overflow = 1. Next, a single-bit group is accepted.
- Lane conflict: in_valid = 4'b0101. Required: lane_conflict = 1 next cycle; two entries ch0 and ch2 carrying the same lane-0 value.
- Done: pulse in_done while 3 entries are queued, then drain with out_ready = 1. Required: out_done = 0 until the cycle after the last pop, then stays 1; mid-stream res_n = 0 clears it.

Source files
------------

// File: rtl/pooled_channel_serializer.sv
// pooled_channel_serializer
//
// Collects pooled results from the convolution/pooling layer and turns them
// into a single-word stream for the next layer. Each cycle, every kernel
// whose strobe is set contributes one word, taken from its shared data lane.
// The words go into a show-ahead FIFO as one all-or-nothing group, in
// ascending kernel order. They leave one per cycle under valid/ready, tagged
// with their kernel index. The block also tracks end-of-image and keeps
// sticky protocol error flags.
//
// Ports:
//   clk           rising-edge clock
//   res_n         synchronous active-low reset
//   in_valid      per-kernel result strobe, one bit per kernel
//   in_data       lane data; kernel k reads lane k % ProcessingElements
//   in_done       upstream pooling-complete level (sampled, made sticky)
//   out_ready     downstream accepts the head word this cycle
//   out_valid     FIFO holds at least one word
//   out_data      head word (0 when empty)
//   out_channel   kernel index of the head word (0 when empty)
//   out_done      image finished and every word drained (sticky)
//   overflow      sticky: a write group was dropped for lack of space
//   lane_conflict sticky: two strobes in one cycle shared a lane
module pooled_channel_serializer #(
   parameter int NumberOfK          = 4,
   parameter int ProcessingElements = 2,
   parameter int BitSize            = 32,
   parameter int FifoDepth          = 16,
   parameter int ChanBits           = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
   input  logic                                        clk,
   input  logic                                        res_n,
   input  logic [NumberOfK-1:0]                        in_valid,
   input  logic [ProcessingElements-1:0][BitSize-1:0]  in_data,
   input  logic                                        in_done,
   input  logic                                        out_ready,
   output logic                                        out_valid,
   output logic [BitSize-1:0]                          out_data,
   output logic [ChanBits-1:0]                         out_channel,
   output logic                                        out_done,
   output logic                                        overflow,
   output logic                                        lane_conflict
);

   localparam int PtrBits   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CountBits = $clog2(FifoDepth + 1);
   localparam int GroupBits = $clog2(NumberOfK + 1);

   logic [BitSize-1:0]   mem_data [FifoDepth];
   logic [ChanBits-1:0]  mem_chan [FifoDepth];
   logic [PtrBits-1:0]   wr_ptr;
   logic [PtrBits-1:0]   rd_ptr;
   logic [CountBits-1:0] count;
   logic                 seen_done;

   logic [GroupBits-1:0] group_size;
   logic [PtrBits-1:0]   slot [NumberOfK];
   logic                 conflict_now;
   logic                 accept;
   logic                 write_accepted;
   logic                 pop;
   logic [CountBits-1:0] count_next;

   // Give each set strobe a slot. The slot is the write pointer plus the
   // number of lower-indexed strobes set this cycle, so the lowest kernel
   // index lands first. Wrap comes from the power-of-two pointer width.
   always_comb begin
      group_size = '0;
      for (int k = 0; k < NumberOfK; k++) begin
         slot[k]    = wr_ptr + PtrBits'(group_size);
         group_size = group_size + GroupBits'(in_valid[k]);
      end
   end

   // Two kernels collide when they share a lane and both strobe together.
   always_comb begin
      conflict_now = 1'b0;
      for (int i = 0; i < NumberOfK; i++) begin
         for (int j = i + 1; j < NumberOfK; j++) begin
            if ((i % ProcessingElements) == (j % ProcessingElements)) begin
               conflict_now = conflict_now | (in_valid[i] & in_valid[j]);
            end
         end
      end
   end

   // Accept or reject the group and update occupancy. Only the registered
   // count decides acceptance. A pop in the same cycle frees no space for
   // this cycle's group.
   always_comb begin
      out_valid      = (count != '0);
      pop            = out_valid && out_ready;
      accept         = (32'(group_size) + 32'(count)) <= 32'(FifoDepth);
      write_accepted = accept && (group_size != '0);
      count_next     = count + (accept ? CountBits'(group_size) : '0)
                             - CountBits'(pop);
   end

   // Show the head word straight from storage. Force it to zero while the
   // FIFO is empty, so stale or uninitialised storage never reaches the
   // outputs.
   always_comb begin
      out_data    = '0;
      out_channel = '0;
      if (out_valid) begin
         out_data    = mem_data[rd_ptr];
         out_channel = mem_chan[rd_ptr];
      end
   end

   // Control state: pointers, occupancy and sticky flags. out_done uses the
   // registered seen_done and count. It therefore rises one cycle after the
   // FIFO empties, or one cycle after in_done is sampled on an empty FIFO.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         seen_done     <= 1'b0;
         out_done      <= 1'b0;
         overflow      <= 1'b0;
         lane_conflict <= 1'b0;
      end else begin
         count <= count_next;
         if (accept) begin
            wr_ptr <= wr_ptr + PtrBits'(group_size);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PtrBits'(1);
         end
         if ((group_size != '0) && !accept) begin
            overflow <= 1'b1;
         end
         if (conflict_now) begin
            lane_conflict <= 1'b1;
         end
         if (seen_done && (count == '0) && !write_accepted) begin
            out_done <= 1'b1;
         end
         if (in_done) begin
            seen_done <= 1'b1;
         end
      end
   end

   // Storage writes. A rejected group writes nothing. Writes in a reset
   // cycle are dropped as well.
   always_ff @(posedge clk) begin
      if (res_n && accept) begin
         for (int k = 0; k < NumberOfK; k++) begin
            if (in_valid[k]) begin
               mem_data[slot[k]] <= in_data[k % ProcessingElements];
               mem_chan[slot[k]] <= ChanBits'(k);
            end
         end
      end
   end

endmodule

// File: tb/tb_pooled_channel_serializer.sv
// tb_pooled_channel_serializer
//
// Drives pooled_channel_serializer through directed scenarios and then
// randomized traffic. A queue-based reference model predicts the stream,
// the sticky flags and out_done. Outputs are compared once per cycle, 1 ns
// after each rising edge.
module tb_pooled_channel_serializer;

   localparam int K  = 4;
   localparam int PE = 2;
   localparam int W  = 32;
   localparam int D  = 16;
   localparam int CB = 2;

   typedef struct packed {
      logic [CB-1:0] ch;
      logic [W-1:0]  data;
   } entry_t;

   logic                  clk = 1'b0;
   logic                  res_n;
   logic [K-1:0]          in_valid;
   logic [PE-1:0][W-1:0]  in_data;
   logic                  in_done;
   logic                  out_ready;
   logic                  out_valid;
   logic [W-1:0]          out_data;
   logic [CB-1:0]         out_channel;
   logic                  out_done;
   logic                  overflow;
   logic                  lane_conflict;

   int test_count = 0;
   int fail_count = 0;

   entry_t model_q[$];
   logic   m_overflow;
   logic   m_conflict;
   logic   m_seen;
   logic   m_done;

   logic [W-1:0] bp_data [6];
   logic [W-1:0] word_a;

   // Free-running clock.
   always #5 clk = ~clk;

   pooled_channel_serializer #(
      .NumberOfK          (K),
      .ProcessingElements (PE),
      .BitSize            (W),
      .FifoDepth          (D),
      .ChanBits           (CB)
   ) dut (
      .clk           (clk),
      .res_n         (res_n),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_done       (in_done),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_channel   (out_channel),
      .out_done      (out_done),
      .overflow      (overflow),
      .lane_conflict (lane_conflict)
   );

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      test_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Compare every DUT output with the model's post-edge state.
   task automatic check_model();
      entry_t head;
      head = '0;
      if (model_q.size() != 0) head = model_q[0];
      check_output("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      check_output("out_data", 64'(out_data), 64'(head.data));
      check_output("out_channel", 64'(out_channel), 64'(head.ch));
      check_output("out_done", 64'(out_done), 64'(m_done));
      check_output("overflow", 64'(overflow), 64'(m_overflow));
      check_output("lane_conflict", 64'(lane_conflict), 64'(m_conflict));
   endtask

   // Reference behaviour for one rising edge, computed from the values
   // driven during the cycle that just ended.
   task automatic model_step();
      int     n;
      bit     accept;
      bit     pop;
      entry_t e;
      n   = $countones(in_valid);
      pop = (model_q.size() != 0) && out_ready;
      if (!res_n) begin
         model_q.delete();
         m_overflow = 1'b0;
         m_conflict = 1'b0;
         m_seen     = 1'b0;
         m_done     = 1'b0;
         return;
      end
      accept = (n <= D - model_q.size());
      for (int i = 0; i < K; i++)
         for (int j = i + 1; j < K; j++)
            if ((i % PE) == (j % PE) && in_valid[i] && in_valid[j]) m_conflict = 1'b1;
      if (n > 0 && !accept) m_overflow = 1'b1;
      if (m_seen && model_q.size() == 0 && !(accept && n > 0)) m_done = 1'b1;
      if (in_done) m_seen = 1'b1;
      if (pop) void'(model_q.pop_front());
      if (accept) begin
         for (int k = 0; k < K; k++) begin
            if (in_valid[k]) begin
               e.ch   = CB'(k);
               e.data = in_data[k % PE];
               model_q.push_back(e);
            end
         end
      end
   endtask

   // One clock cycle: check outputs, drive inputs, advance one edge.
   task automatic apply_stimulus(input logic [K-1:0] v, input logic [W-1:0] lane0,
                                 input logic [W-1:0] lane1, input logic done,
                                 input logic ready, input logic rst_n);
      check_model();
      in_valid   = v;
      in_data[0] = lane0;
      in_data[1] = lane1;
      in_done    = done;
      out_ready  = ready;
      res_n      = rst_n;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      in_valid   = '0;
      in_data    = '0;
      in_done    = 1'b0;
      out_ready  = 1'b0;
      res_n      = 1'b0;
      model_q.delete();
      m_overflow = 1'b0;
      m_conflict = 1'b0;
      m_seen     = 1'b0;
      m_done     = 1'b0;
      @(posedge clk);
      #1;

      // Reset for two cycles, then idle for ten cycles with all outputs at 0.
      repeat (2) apply_stimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
      repeat (10) apply_stimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
      check_output("idle_valid", 64'(out_valid), 64'(0));
      check_output("idle_data", 64'(out_data), 64'(0));

      // Ordered groups on both lanes.
      apply_stimulus(4'b0011, 32'hA, 32'hB, 1'b0, 1'b1, 1'b1);
      check_output("ord0_ch", 64'(out_channel), 64'(0));
      check_output("ord0_data", 64'(out_data), 64'(32'hA));
      apply_stimulus(4'b1100, 32'hC, 32'hD, 1'b0, 1'b1, 1'b1);
      check_output("ord1_ch", 64'(out_channel), 64'(1));
      check_output("ord1_data", 64'(out_data), 64'(32'hB));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("ord2_ch", 64'(out_channel), 64'(2));
      check_output("ord2_data", 64'(out_data), 64'(32'hC));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("ord3_ch", 64'(out_channel), 64'(3));
      check_output("ord3_data", 64'(out_data), 64'(32'hD));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("ord_empty", 64'(out_valid), 64'(0));

      // Backpressure: queue six single-strobe groups, then drain them.
      for (int i = 0; i < 6; i++) begin
         bp_data[i] = $urandom;
         apply_stimulus(K'(1 << (i % K)), bp_data[i], bp_data[i], 1'b0, 1'b0, 1'b1);
         check_output("bp_head", 64'(out_data), 64'(bp_data[0]));
      end
      apply_stimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
      check_output("bp_hold_data", 64'(out_data), 64'(bp_data[0]));
      check_output("bp_hold_ch", 64'(out_channel), 64'(0));
      for (int i = 1; i <= 6; i++) begin
         apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
         if (i < 6) begin
            check_output("bp_drain_data", 64'(out_data), 64'(bp_data[i]));
            check_output("bp_drain_ch", 64'(out_channel), 64'(i % K));
         end else begin
            check_output("bp_drained", 64'(out_valid), 64'(0));
         end
      end

      // Overflow: fill to 15, reject a two-word group, accept one word, then
      // reject a word on a full FIFO even while a pop occurs.
      for (int i = 0; i < 7; i++) begin
         apply_stimulus((i % 2 == 0) ? 4'b0011 : 4'b1100, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      end
      apply_stimulus(4'b0001, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      check_output("ovf_before", 64'(overflow), 64'(0));
      apply_stimulus(4'b0011, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      check_output("ovf_set", 64'(overflow), 64'(1));
      apply_stimulus(4'b0001, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      apply_stimulus(4'b0001, $urandom, $urandom, 1'b0, 1'b1, 1'b1);
      repeat (17) apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("ovf_drained", 64'(out_valid), 64'(0));
      check_output("ovf_sticky", 64'(overflow), 64'(1));
      apply_stimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
      check_output("ovf_reset", 64'(overflow), 64'(0));

      // Lane conflict: kernels 0 and 2 both read lane 0.
      word_a = $urandom;
      apply_stimulus(4'b0101, word_a, $urandom, 1'b0, 1'b0, 1'b1);
      check_output("lc_flag", 64'(lane_conflict), 64'(1));
      check_output("lc_ch0", 64'(out_channel), 64'(0));
      check_output("lc_data0", 64'(out_data), 64'(word_a));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("lc_ch2", 64'(out_channel), 64'(2));
      check_output("lc_data2", 64'(out_data), 64'(word_a));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      apply_stimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Done while three words are queued, then drain, then reset.
      apply_stimulus(4'b0001, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      apply_stimulus(4'b0010, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
      apply_stimulus(4'b0100, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("done_last_pop", 64'(out_done), 64'(0));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("done_rise", 64'(out_done), 64'(1));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("done_hold", 64'(out_done), 64'(1));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b0);
      check_output("done_reset", 64'(out_done), 64'(0));

      // Done arriving on an already-empty FIFO.
      apply_stimulus('0, '0, '0, 1'b1, 1'b1, 1'b1);
      check_output("done_empty_t0", 64'(out_done), 64'(0));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_output("done_empty_t1", 64'(out_done), 64'(1));
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic: heavy backpressure first, then mostly draining.
      for (int c = 0; c < 400; c++) begin
         logic [K-1:0] v;
         logic         rdy;
         v = K'($urandom_range(0, 15));
         if (c >= 200 && $urandom_range(0, 2) != 0) v = '0;
         rdy = (c < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
         apply_stimulus(v, $urandom, $urandom, ($urandom_range(0, 31) == 0), rdy,
                        ($urandom_range(0, 79) != 0));
      end
      apply_stimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_model();

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
